tdm_demux4: RTL and testbench

//  Receive-side 1:4 time-division demultiplexer; the inverse of the team's 4:1 channel mux.

---
 rtl/tdm_pkg.sv | 8 +
 rtl/tdm_slot_ctr.sv | 33 +++
 rtl/tdm_demux4.sv | 128 ++++++++++++
 tb/tb_tdm_demux4.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the 1:4 TDM receive demultiplexer.
// Optional shadow frame bank: define TDM_DEMUX_FRAME_BUF_EN.
package tdm_pkg;
  localparam int NUM_CH = 4;
  typedef logic [1:0] slot_t;
  typedef enum logic {HUNT, LOCK} state_t;
  localparam slot_t LAST_SLOT = 2'd3;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: holds the slot expected on the next beat.
// Loads 1 when a start-of-frame beat is taken as slot 0.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  adv_i,
  output slot_t slot_o,
  output logic  last_o
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    unique case (1'b1)
      load_i:  slot_d = 2'd1;
      adv_i:   slot_d = slot_q + 2'd1;
      default: slot_d = slot_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM demultiplexer with sof alignment.
// Define TDM_DEMUX_FRAME_BUF_EN for atomic whole-frame updates.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] ch0_data,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic [DATA_W-1:0] ch3_data,
  output logic [3:0]        ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  typedef logic [DATA_W-1:0] word_t;

  state_t state_q, state_d;
  word_t  ch_q [NUM_CH];
  word_t  ch_d [NUM_CH];
  logic [3:0] vld_q, vld_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  slot_t  slot;
  slot_t  wr_slot;
  logic   last;
  logic   sof_hit;
  logic   accept;
  logic   close;

  assign sof_hit = in_valid & in_sof;
  assign accept  = sof_hit | (in_valid & (state_q == LOCK));
  assign wr_slot = sof_hit ? slot_t'(0) : slot;
  assign close   = accept & ~in_sof & last;

  tdm_slot_ctr u_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (sof_hit),
    .adv_i  (accept & ~in_sof),
    .slot_o (slot),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: if (sof_hit) state_d = LOCK;
      LOCK: state_d = LOCK;
    endcase
  end

`ifdef TDM_DEMUX_FRAME_BUF_EN
  word_t sh_q [NUM_CH];
  word_t sh_d [NUM_CH];

  always_comb begin
    ch_d   = ch_q;
    sh_d   = sh_q;
    vld_d  = '0;
    done_d = close;
    err_d  = sof_hit & (state_q == LOCK) & (slot != '0);
    // a misplaced sof throws away the partly collected frame
    if (err_d) begin
      for (int i = 0; i < NUM_CH; i++) sh_d[i] = '0;
    end
    if (accept) sh_d[wr_slot] = in_data;
    if (close) begin
      for (int i = 0; i < NUM_CH - 1; i++) ch_d[i] = sh_q[i];
      ch_d[NUM_CH-1] = in_data;
      vld_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) sh_q[i] <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end
`else
  always_comb begin
    ch_d   = ch_q;
    vld_d  = '0;
    done_d = close;
    err_d  = sof_hit & (state_q == LOCK) & (slot != '0);
    if (accept) begin
      ch_d[wr_slot]  = in_data;
      vld_d[wr_slot] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      vld_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ch0_data   = ch_q[0];
  assign ch1_data   = ch_q[1];
  assign ch2_data   = ch_q[2];
  assign ch3_data   = ch_q[3];
  assign ch_valid   = vld_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 against a slot-level frame model.
// Honours TDM_DEMUX_FRAME_BUF_EN when the design is built with it.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic       frame_done, sync_err, locked;

  int checks = 0;
  int failures = 0;

  bit         m_lock;
  int         m_slot;
  logic [7:0] m_ch [4];
  logic [7:0] m_sh [4];
  logic [3:0] m_v;
  bit         m_fd, m_se;

  always #5 clk = ~clk;

  tdm_demux4 #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .ch0_data   (ch0),
    .ch1_data   (ch1),
    .ch2_data   (ch2),
    .ch3_data   (ch3),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  function automatic logic [7:0] dut_ch(input int i);
    case (i)
      0:       return ch0;
      1:       return ch1;
      2:       return ch2;
      default: return ch3;
    endcase
  endfunction

  task automatic m_reset();
    m_lock = 0;
    m_slot = 0;
    m_v = '0;
    m_fd = 0;
    m_se = 0;
    for (int i = 0; i < 4; i++) begin
      m_ch[i] = '0;
      m_sh[i] = '0;
    end
  endtask

  task automatic m_put(input int i, input logic [7:0] d, input bit done);
`ifdef TDM_DEMUX_FRAME_BUF_EN
    m_sh[i] = d;
    if (done) begin
      for (int k = 0; k < 4; k++) m_ch[k] = m_sh[k];
      m_v = 4'hf;
      m_fd = 1;
    end
`else
    m_ch[i] = d;
    m_v[i] = 1'b1;
    m_fd = done;
`endif
  endtask

  // drive one cycle from a negedge; return at the next negedge
  task automatic step(input bit v, input bit s, input logic [7:0] d);
    in_valid = v;
    in_sof = s;
    in_data = d;
    m_v = '0;
    m_fd = 0;
    m_se = 0;
    if (v && s) begin
      if (m_lock && m_slot != 0) m_se = 1;
      m_lock = 1;
      m_put(0, d, 0);
      m_slot = 1;
    end else if (v && m_lock) begin
      m_put(m_slot, d, m_slot == 3);
      m_slot = (m_slot + 1) % 4;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_sof = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ch(i) !== 8'h00) begin
        failures++;
        $display("FAIL reset_ch%0d got=%h exp=00", i, dut_ch(i));
      end
    end
    checks++;
    if ({ch_valid, frame_done, sync_err, locked} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {ch_valid, frame_done, sync_err, locked});
    end
  endtask

  task automatic test_basic();
    logic [7:0] d [4];
    d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, k == 0, d[k]);
      checks++;
      if (ch_valid !== m_v) begin
        failures++;
        $display("FAIL basic_valid%0d got=%b exp=%b", k, ch_valid, m_v);
      end
      checks++;
      if (frame_done !== (k == 3)) begin
        failures++;
        $display("FAIL basic_done%0d got=%b exp=%b", k, frame_done, k == 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ch(i) !== d[i]) begin
        failures++;
        $display("FAIL basic_ch%0d got=%h exp=%h", i, dut_ch(i), d[i]);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL basic_locked got=%b exp=1", locked);
    end
  endtask

  task automatic test_hunt();
    do_reset();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    checks++;
    if ({ch_valid, locked, ch0, ch1} !== 21'b0) begin
      failures++;
      $display("FAIL hunt_drop got=%b/%b/%h/%h exp=0",
               ch_valid, locked, ch0, ch1);
    end
    step(1, 1, 8'h33);
    checks++;
    if (ch0 !== m_ch[0] || ch_valid !== m_v) begin
      failures++;
      $display("FAIL hunt_sof ch0=%h v=%b exp=%h/%b",
               ch0, ch_valid, m_ch[0], m_v);
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL hunt_locked got=%b exp=1", locked);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    step(1, 1, 8'hA0);
    step(1, 0, 8'hB1);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 8'hEE);
      checks++;
      if (ch_valid !== 4'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL gap%0d v=%b fd=%b exp=0000/0", g, ch_valid, frame_done);
      end
    end
    step(1, 0, 8'hC2);
    step(1, 0, 8'hD3);
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 32'hA0B1C2D3 || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL gaps_frame got=%h%h%h%h fd=%b exp=a0b1c2d3/1",
               ch0, ch1, ch2, ch3, frame_done);
    end
  endtask

  task automatic test_sync_err();
    int fd_cnt = 0;
    do_reset();
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h05);
    checks++;
    if (sync_err !== 1'b1 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL serr_pulse se=%b fd=%b exp=1/0", sync_err, frame_done);
    end
    checks++;
    if (ch0 !== m_ch[0] || locked !== 1'b1) begin
      failures++;
      $display("FAIL serr_ch0 got=%h lk=%b exp=%h/1", ch0, locked, m_ch[0]);
    end
    step(1, 0, 8'h06);
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL serr_once got=%b exp=0", sync_err);
    end
    step(1, 0, 8'h07);
    fd_cnt += frame_done;
    step(1, 0, 8'h08);
    checks++;
    if (frame_done !== 1'b1 || ch3 !== 8'h08 || fd_cnt != 0) begin
      failures++;
      $display("FAIL serr_done fd=%b ch3=%h early=%0d exp=1/08/0",
               frame_done, ch3, fd_cnt);
    end
    checks++;
    if (ch0 !== 8'h05) begin
      failures++;
      $display("FAIL serr_frame ch0=%h exp=05", ch0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 1, 8'h5A);
    step(1, 0, 8'h6B);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ch0, ch1, ch2, ch3, ch_valid, frame_done, sync_err, locked} !== 39'b0) begin
      failures++;
      $display("FAIL areset got=%h%h%h%h %b%b%b%b exp=0",
               ch0, ch1, ch2, ch3, ch_valid, frame_done, sync_err, locked);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h44);
    checks++;
    if (ch_valid !== 4'b0 || locked !== 1'b0 || ch1 !== 8'h00) begin
      failures++;
      $display("FAIL areset_drop v=%b lk=%b ch1=%h exp=0000/0/00",
               ch_valid, locked, ch1);
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    int se_cnt = 0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] d;
        d = (f == 1) ? 8'hF0 + 8'(k) : 8'($urandom);
        step(1, k == 0, d);
        fd_cnt += frame_done;
        se_cnt += sync_err;
      end
    end
    checks++;
    if (fd_cnt != 2 || se_cnt != 0) begin
      failures++;
      $display("FAIL b2b_pulses fd=%0d se=%0d exp=2/0", fd_cnt, se_cnt);
    end
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 32'hF0F1F2F3) begin
      failures++;
      $display("FAIL b2b_frame got=%h%h%h%h exp=f0f1f2f3", ch0, ch1, ch2, ch3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit v, s;
      v = ($urandom % 10) < 7;
      s = (m_slot == 0 && ($urandom % 4) != 0) || ($urandom % 12) == 0;
      step(v, s, 8'($urandom));
      checks++;
      if ({ch0, ch1, ch2, ch3} !== {m_ch[0], m_ch[1], m_ch[2], m_ch[3]}) begin
        failures++;
        $display("FAIL rnd_data n=%0d got=%h%h%h%h exp=%h%h%h%h", n,
                 ch0, ch1, ch2, ch3, m_ch[0], m_ch[1], m_ch[2], m_ch[3]);
      end
      checks++;
      if ({ch_valid, frame_done, sync_err, locked} !== {m_v, m_fd, m_se, m_lock}) begin
        failures++;
        $display("FAIL rnd_flags n=%0d got=%b exp=%b", n,
                 {ch_valid, frame_done, sync_err, locked},
                 {m_v, m_fd, m_se, m_lock});
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_hunt();
    test_gaps();
    test_sync_err();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
